serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/serial_subtractor_full_subtractor.sv | 11 +
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared encodings and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;
  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial Diff = A - B - Bin: one full-subtractor cell walked LSB-first over WIDTH clocks.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fs_d, fs_bout;

  full_subtractor u_fs (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        diff_d[cnt_q] = fs_d;
        borrow_d      = fs_bout;
        cnt_d         = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          bout_d  = fs_bout;
          state_d = DONE;
        end
      end
      DONE: begin
        // Result stays put after hand-off; only the valid flag drops.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign Diff      = diff_q;
  assign Bout      = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed table, hand-written corner sequences, exhaustive and random sweeps.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] A, B;
  logic         Bin;
  logic         out_valid, out_ready;
  logic [W-1:0] Diff;
  logic         Bout, busy;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .Bout(Bout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    int           stall;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: subtract at WIDTH+1 bits; the top bit is the borrow-out.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return (W+1)'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid after the accepting edge; returns edges counted.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 4*W) begin
      out_ready = 1'($urandom);
      tick();
      lat++;
    end
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input int stall, input logic [W-1:0] ed, input logic eb);
    int lat;
    lat = 0;
    while (!in_ready && lat < 50) begin tick(); lat++; end
    chk("in_ready_before_op", 32'(in_ready), 32'd1);
    A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    wait_done(lat);
    chk("latency", 32'(lat), 32'(W));
    chk("result", 32'({Bout, Diff}), 32'({eb, ed}));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_hold", 32'({out_valid, Bout, Diff}), 32'({1'b1, eb, ed}));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consumed", 32'({out_valid, in_ready, Bout, Diff}), 32'({1'b0, 1'b1, eb, ed}));
  endtask

  vec_t vecs[6];

  initial begin
    int lat;
    logic [W:0] r;
    vecs[0] = '{4'd9,  4'd5,  1'b0, 0, 4'd4,  1'b0};
    vecs[1] = '{4'd3,  4'd5,  1'b0, 0, 4'd14, 1'b1};
    vecs[2] = '{4'd0,  4'd0,  1'b1, 1, 4'd15, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 1'b0, 0, 4'd0,  1'b0};
    vecs[4] = '{4'd12, 4'd7,  1'b1, 5, 4'd4,  1'b0};
    vecs[5] = '{4'd0,  4'd1,  1'b0, 2, 4'd15, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Bin = 1'b0;
    #12;
    chk("reset_state", 32'({in_ready, out_valid, busy, Bout, Diff}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0}));
    rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].stall, vecs[i].exp_diff, vecs[i].exp_bout);

    // Requests presented during BUSY must be ignored until IDLE returns.
    A = 4'd10; B = 4'd3; Bin = 1'b0; in_valid = 1'b1;
    tick();
    A = 4'd1; B = 4'd2;
    chk("busy_in_ready", 32'({busy, in_ready}), 32'({1'b1, 1'b0}));
    wait_done(lat);
    chk("overlap_latency", 32'(lat), 32'(W));
    chk("overlap_result", 32'({in_ready, Bout, Diff}), 32'({1'b0, 1'b0, 4'd7}));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("overlap_idle", 32'({in_ready, out_valid}), 32'({1'b1, 1'b0}));
    tick();
    in_valid = 1'b0;
    chk("second_accept", 32'(busy), 32'd1);
    wait_done(lat);
    chk("second_result", 32'({Bout, Diff}), 32'({1'b1, 4'd15}));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset in the 2nd BUSY cycle.
    A = 4'd11; B = 4'd2; Bin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({out_valid, busy, in_ready, Bout, Diff}), 32'({1'b0, 1'b0, 1'b1, 1'b0, 4'd0}));
    tick();
    chk("reset_held", 32'({busy, out_valid}), 32'd0);
    rst_n = 1'b1;
    run_op(4'd6, 4'd2, 1'b0, 0, 4'd4, 1'b0);

    // Exhaustive sweep with random stalls.
    for (int k = 0; k < (1 << (2*W+1)); k++) begin
      logic [W-1:0] a, b;
      logic bi;
      a = W'(k); b = W'(k >> W); bi = 1'(k >> (2*W));
      r = ref_sub(a, b, bi);
      run_op(a, b, bi, int'($urandom_range(0, 3)), r[W-1:0], r[W]);
    end

    // Random operations.
    for (int k = 0; k < 100; k++) begin
      logic [W-1:0] a, b;
      logic bi;
      a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
      r = ref_sub(a, b, bi);
      run_op(a, b, bi, int'($urandom_range(0, 2)), r[W-1:0], r[W]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
